// File: rtl/bpu_pht_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bpu_pkg
// Shared definitions for the PHT controller slice:
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - sat_ctr(): saturating counter update
//   - upd_entry_t: one queued counter update {index, old_ctr, taken}
//   - pht_state_t: controller states (init sweep / normal run)
// upd_entry_t carries a fixed-width index field of UPD_IDX_MAX_W bits. Users
// with a narrower index zero-extend on write and slice on read, so the
// controller supports any IDX_W up to UPD_IDX_MAX_W.
// -----------------------------------------------------------------------------
package bpu_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int UPD_IDX_MAX_W = 16;

    typedef struct packed {
        logic [UPD_IDX_MAX_W-1:0] index;
        logic [1:0]               old_ctr;
        logic                     taken;
    } upd_entry_t;

    typedef enum logic {
        PHT_INIT = 1'b0,
        PHT_RUN  = 1'b1
    } pht_state_t;

    // Taken moves toward ST, not-taken toward SNT, clamped at both ends.
    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            if (ctr == ST) res = ST;
            else           res = ctr + 2'b01;
        end else begin
            if (ctr == SNT) res = SNT;
            else            res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/bpu_pht_ctrl_upd_fifo.sv
// -----------------------------------------------------------------------------
// bpu_upd_fifo
// Synchronous FIFO of pending PHT counter updates.
// Ports:
//   clk, rst         clock, synchronous active-high reset (empties the queue)
//   push, din        enqueue din (caller guarantees not full)
//   pop              dequeue head (caller guarantees not empty)
//   full, empty      occupancy flags
//   count            number of valid entries
//   head             oldest entry
//   entries[k]       entries in queue order: entries[0] is the head,
//                    entries[count-1] the newest; slots k >= count are stale
// -----------------------------------------------------------------------------
module bpu_upd_fifo
    import bpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  upd_entry_t       din,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output upd_entry_t       head,
    output upd_entry_t       entries [DEPTH]
);

    upd_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Entry storage; contents need no reset because count_r qualifies them.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PTR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Status flags and queue-ordered view of the storage.
    always_comb begin
        full  = (count_r == CNT_W'(DEPTH));
        empty = (count_r == CNT_W'(0));
        count = count_r;
        head  = mem_r[rd_ptr_r];
        for (int k = 0; k < DEPTH; k++) begin
            entries[k] = mem_r[rd_ptr_r + PTR_W'(k)];
        end
    end

endmodule

// File: rtl/bpu_pht_ctrl.sv
// -----------------------------------------------------------------------------
// bpu_pht_ctrl
// Controller/arbiter for a single-port PHT RAM of 2-bit saturating counters.
// After reset it sweeps every entry to INIT_CTR (one write per cycle), then
// shares the RAM port between fetch lookups (reads) and queued branch-
// resolution updates (writes). Lookups win unless the update queue is full or
// its head has been denied MAX_WAIT-1 cycles, in which case the head is forced.
// Optional build macro: BPU_PHT_BYPASS_EN forwards the newest queued update
// for a looked-up index into the lookup response instead of the stale RAM data.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   lk_valid/lk_index/lk_ready    lookup request / accepted this cycle
//   lk_rvalid/lk_ctr              lookup response, one cycle after acceptance
//   up_valid/up_index/up_old_ctr/up_taken/up_ready   update enqueue
//   init_busy                     init sweep in progress (or in reset)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata       PHT RAM port
// -----------------------------------------------------------------------------
module bpu_pht_ctrl
    import bpu_pkg::*;
#(
    parameter int         IDX_W      = 10,
    parameter int         FIFO_DEPTH = 4,
    parameter int         MAX_WAIT   = 8,
    parameter logic [1:0] INIT_CTR   = 2'b10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_index,
    output logic             lk_ready,
    output logic             lk_rvalid,
    output logic [1:0]       lk_ctr,
    input  logic             up_valid,
    input  logic [IDX_W-1:0] up_index,
    input  logic [1:0]       up_old_ctr,
    input  logic             up_taken,
    output logic             up_ready,
    output logic             init_busy,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [1:0]       mem_wdata,
    input  logic [1:0]       mem_rdata
);

    localparam int              WAIT_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT - 1);
    localparam int              CNT_W    = $clog2(FIFO_DEPTH) + 1;

    pht_state_t        state_r, state_next;
    logic [IDX_W-1:0]  ptr_r, ptr_next;
    logic [WAIT_W-1:0] wait_r, wait_next;
    logic              lk_rvalid_r;
    logic              grant;
    logic              rd_req;
    logic              force_wr;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    upd_entry_t        fifo_head;
    upd_entry_t        fifo_entries [FIFO_DEPTH];
    upd_entry_t        fifo_din;
    logic              unused_fold;

    assign fifo_din = '{index: UPD_IDX_MAX_W'(up_index), old_ctr: up_old_ctr, taken: up_taken};

    bpu_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (up_valid && up_ready),
        .pop     (grant),
        .din     (fifo_din),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head    (fifo_head),
        .entries (fifo_entries)
    );

    // State, sweep pointer, starvation counter and response-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= PHT_INIT;
            ptr_r       <= '0;
            wait_r      <= '0;
            lk_rvalid_r <= 1'b0;
        end else begin
            state_r     <= state_next;
            ptr_r       <= ptr_next;
            wait_r      <= wait_next;
            lk_rvalid_r <= rd_req;
        end
    end

    // Next state, port arbitration and RAM drive; all outputs idle in reset.
    always_comb begin
        state_next = state_r;
        ptr_next   = ptr_r;
        wait_next  = '0;
        grant      = 1'b0;
        rd_req     = 1'b0;
        lk_ready   = 1'b0;
        up_ready   = 1'b0;
        init_busy  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 2'b00;
        // Full implies non-empty, so force_wr always has a head to write.
        force_wr   = fifo_full || (!fifo_empty && (wait_r == WAIT_MAX));
        if (rst) begin
            init_busy = 1'b1;
        end else begin
            case (state_r)
                PHT_INIT: begin
                    init_busy = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = ptr_r;
                    mem_wdata = INIT_CTR;
                    ptr_next  = ptr_r + IDX_W'(1);
                    if (ptr_r == {IDX_W{1'b1}}) state_next = PHT_RUN;
                    else                        state_next = PHT_INIT;
                end
                PHT_RUN: begin
                    // No pass-through when full: a pop this cycle does not open a slot.
                    up_ready = !fifo_full;
                    if (force_wr)         grant  = 1'b1;
                    else if (lk_valid)    rd_req = 1'b1;
                    else if (!fifo_empty) grant  = 1'b1;
                    else                  grant  = 1'b0;

                    if (grant) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = fifo_head.index[IDX_W-1:0];
                        mem_wdata = sat_ctr(fifo_head.old_ctr, fifo_head.taken);
                    end else if (rd_req) begin
                        lk_ready  = 1'b1;
                        mem_en    = 1'b1;
                        mem_addr  = lk_index;
                    end else begin
                        mem_en    = 1'b0;
                    end

                    if (!fifo_empty && !grant) begin
                        if (wait_r == WAIT_MAX) wait_next = wait_r;
                        else                    wait_next = wait_r + WAIT_W'(1);
                    end else begin
                        wait_next = '0;
                    end
                end
                default: begin
                    state_next = PHT_INIT;
                    ptr_next   = '0;
                end
            endcase
        end
    end

    // Fold of FIFO fields not otherwise consumed (upper index bits, count).
    always_comb begin
        unused_fold = (^fifo_head) ^ (^fifo_count);
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            unused_fold = unused_fold ^ (^fifo_entries[k]);
        end
    end

`ifdef BPU_PHT_BYPASS_EN
    logic       byp_hit_s, byp_hit_r;
    logic [1:0] byp_ctr_s, byp_ctr_r;

    // Newest matching queued update wins: later queue positions override earlier.
    always_comb begin
        byp_hit_s = 1'b0;
        byp_ctr_s = 2'b00;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if ((CNT_W'(k) < fifo_count) &&
                (fifo_entries[k].index[IDX_W-1:0] == lk_index)) begin
                byp_hit_s = 1'b1;
                byp_ctr_s = sat_ctr(fifo_entries[k].old_ctr, fifo_entries[k].taken);
            end else begin
                byp_hit_s = byp_hit_s;
            end
        end
    end

    // Capture the forwarded value alongside the RAM read it replaces.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_hit_r <= 1'b0;
            byp_ctr_r <= 2'b00;
        end else if (rd_req) begin
            byp_hit_r <= byp_hit_s;
            byp_ctr_r <= byp_ctr_s;
        end else begin
            byp_hit_r <= 1'b0;
            byp_ctr_r <= 2'b00;
        end
    end
`endif

    // Lookup response; a response pending across a reset is dropped.
    always_comb begin
        lk_rvalid = lk_rvalid_r && !rst;
        if (lk_rvalid) begin
`ifdef BPU_PHT_BYPASS_EN
            if (byp_hit_r) lk_ctr = byp_ctr_r;
            else           lk_ctr = mem_rdata;
`else
            lk_ctr = mem_rdata;
`endif
        end else begin
            lk_ctr = 2'b00;
        end
    end

endmodule
